// File: rtl/cache_nway_wb.sv
// cache_nway_wb: write-back, write-allocate, num_ways-way set-associative cache
// with tree-PLRU replacement and a 256-bit line interface to memory.
// Optional feature: define CACHE_PERF_COUNTERS_EN to add hit_count/miss_count.
module cache_nway_wb #(
  parameter  int s_offset = 5,
  parameter  int s_index  = 3,
  parameter  int num_ways = 4,
  localparam int s_tag    = 32 - s_offset - s_index
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_byte_enable256,
  input  logic [255:0] mem_wdata256,
  output logic [255:0] mem_rdata256,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef CACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int num_sets = 2 ** s_index;
  localparam int WAY_W    = $clog2(num_ways);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_e;

  state_e state_q, state_d;

  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:0] valid_d [num_sets];
  logic [num_ways-1:0] dirty_q [num_sets];
  logic [num_ways-1:0] dirty_d [num_sets];
  logic [num_ways-2:0] plru_q  [num_sets];
  logic [num_ways-2:0] plru_d  [num_sets];
  logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
  logic [255:0]        data_q  [num_sets][num_ways];

  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [s_index-1:0]  vidx_q, vidx_d;

  logic [s_index-1:0]  idx;
  logic [s_tag-1:0]    req_tag;
  logic                req;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [255:0]        hit_line;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    plru_way;
  logic [WAY_W-1:0]    victim_sel;
  logic [255:0]        merged;

  logic                line_we;
  logic                tag_we;
  logic [s_index-1:0]  line_set;
  logic [WAY_W-1:0]    line_way;
  logic [255:0]        line_wdata;

  logic                unused_addr_bits;

  assign idx              = mem_address[s_offset +: s_index];
  assign req_tag          = mem_address[31 -: s_tag];
  assign req              = mem_read | mem_write;
  assign unused_addr_bits = ^mem_address[s_offset-1:0];

  // Heap-ordered tree: node n lives at bit n-1; a 1 steers the victim right.
  function automatic logic [WAY_W-1:0] plru_pick(input logic [num_ways-2:0] bits);
    int unsigned node;
    node = 1;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      node = bits[node-1] ? 2 * node + 1 : 2 * node;
    end
    return WAY_W'(node - num_ways);
  endfunction

  // Make every node on the path to way point at the opposite subtree.
  function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] bits,
                                                     input logic [WAY_W-1:0]    way);
    logic [num_ways-2:0] res;
    int unsigned node;
    res  = bits;
    node = 1;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      res[node-1] = ~way[WAY_W-1-l];
      node = way[WAY_W-1-l] ? 2 * node + 1 : 2 * node;
    end
    return res;
  endfunction

  // Tag compare, lowest invalid way and PLRU candidate for the requested set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < num_ways; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    hit_line   = data_q[idx][hit_way];
    plru_way   = plru_pick(plru_q[idx]);
    victim_sel = inv_found ? inv_way : plru_way;
    for (int unsigned b = 0; b < 32; b++) begin
      merged[b*8 +: 8] = mem_byte_enable256[b] ? mem_wdata256[b*8 +: 8] : hit_line[b*8 +: 8];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req) state_d = LOOKUP;
      LOOKUP: begin
        if (!req || hit) state_d = IDLE;
        else if (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) state_d = WRITEBACK;
        else state_d = FILL;
      end
      WRITEBACK: if (pmem_resp) state_d = FILL;
      FILL:      if (pmem_resp) state_d = LOOKUP;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata256 = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      LOOKUP: begin
        if (req && hit) begin
          mem_resp     = 1'b1;
          mem_rdata256 = hit_line;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[vidx_q][victim_q], vidx_q, {s_offset{1'b0}}};
        pmem_wdata   = data_q[vidx_q][victim_q];
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
      end
      default: ;
    endcase
  end

  // Metadata updates, victim capture and line/tag write requests.
  always_comb begin
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    plru_d     = plru_q;
    victim_d   = victim_q;
    vidx_d     = vidx_q;
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_set   = idx;
    line_way   = hit_way;
    line_wdata = merged;
    case (state_q)
      LOOKUP: begin
        if (req && hit) begin
          plru_d[idx] = plru_touch(plru_q[idx], hit_way);
          if (mem_write) begin
            line_we              = 1'b1;
            dirty_d[idx][hit_way] = 1'b1;
          end
        end else if (req) begin
          victim_d = victim_sel;
          vidx_d   = idx;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          line_we                     = 1'b1;
          tag_we                      = 1'b1;
          line_set                    = vidx_q;
          line_way                    = victim_q;
          line_wdata                  = pmem_rdata;
          valid_d[vidx_q][victim_q]   = 1'b1;
          dirty_d[vidx_q][victim_q]   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and metadata registers; reset also blocks any pending array write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      vidx_q   <= '0;
      for (int unsigned s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      vidx_q   <= vidx_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      plru_q   <= plru_d;
    end
  end

  // Line and tag storage, no reset.
  always_ff @(posedge clk) begin
    if (rst && line_we) data_q[line_set][line_way] <= line_wdata;
    if (rst && tag_we)  tag_q[line_set][line_way]  <= req_tag;
  end

`ifdef CACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Count served hits and lookups that leave for memory.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (mem_resp) hit_count_d = hit_count_q + 32'd1;
    if (state_q == LOOKUP && req && !hit) miss_count_d = miss_count_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_nway_wb.sv
// Testbench for cache_nway_wb: directed vector table, reset-abort sequence and
// randomized traffic checked against a behavioural cache/memory model.
module tb_cache_nway_wb;

  localparam int NW = 4;
  localparam int NS = 8;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_wdata256;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef CACHE_PERF_COUNTERS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int tests = 0;
  int fails = 0;

  cache_nway_wb dut (
    .clk               (clk),
    .rst               (rst),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_byte_enable256(mem_byte_enable256),
    .mem_wdata256      (mem_wdata256),
    .mem_rdata256      (mem_rdata256),
    .mem_resp          (mem_resp),
    .pmem_address      (pmem_address),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_wdata        (pmem_wdata),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp)
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory and model state ----------------
  logic [255:0] pmem [int unsigned];
  logic [255:0] gold [int unsigned];
  bit           mv [NS][NW];
  bit           md [NS][NW];
  int unsigned  mt [NS][NW];
  bit           mp [NS][NW];
  bit           mem_auto   = 1'b1;
  bit           force_resp = 1'b0;
  int           mem_cnt;

  function automatic logic [255:0] init_line(input int unsigned la);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = (la * 32'h9E3779B1) ^ (k * 32'h01010101) ^ 32'h5A5A0000;
    return r;
  endfunction

  function automatic logic [255:0] pmem_get(input int unsigned la);
    if (pmem.exists(la)) return pmem[la];
    return init_line(la);
  endfunction

  function automatic logic [255:0] gold_get(input int unsigned la);
    if (gold.exists(la)) return gold[la];
    return init_line(la);
  endfunction

  // Walk the PLRU tree over way ranges; mp=1 sends the victim to the upper half.
  function automatic int m_victim(input int s);
    int node = 1, lo = 0, span = NW;
    while (span > 1) begin
      int half = span / 2;
      if (mp[s][node]) begin
        lo   = lo + half;
        node = 2 * node + 1;
      end else node = 2 * node;
      span = half;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int node = 1, lo = 0, span = NW;
    while (span > 1) begin
      int half = span / 2;
      if (w < lo + half) begin
        mp[s][node] = 1'b1;
        node = 2 * node;
      end else begin
        mp[s][node] = 1'b0;
        lo   = lo + half;
        node = 2 * node + 1;
      end
      span = half;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
        mp[s][w] = 1'b0;
      end
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory: answers any read/write request 3 cycles after it appears.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    mem_cnt    = 0;
    forever begin
      @(negedge clk);
      pmem_resp = force_resp;
      if (mem_auto && rst && (pmem_read || pmem_write)) begin
        mem_cnt++;
        if (mem_cnt == 3) begin
          mem_cnt   = 0;
          pmem_resp = 1'b1;
          if (pmem_write) pmem[pmem_address >> 5] = pmem_wdata;
          else pmem_rdata = pmem_get(pmem_address >> 5);
        end
      end else mem_cnt = 0;
    end
  end

  // One CPU request, checked against the model.
  task automatic do_req(input logic [31:0] addr, input bit we, input bit both,
                        input logic [31:0] be, input logic [255:0] wd,
                        output bit o_hit, output bit o_wb, output logic [31:0] o_wb_addr,
                        output bit o_fill, output logic [31:0] o_fill_addr,
                        output logic [255:0] o_rdata);
    int s, w, lat;
    int unsigned tag, la;
    bit p_hit, p_wb, got, excl_bad, idle_nz, wb_unstable, align_bad, resp_long;
    logic [31:0] p_wb_addr;
    logic [255:0] p_wb_data, exp_rd, line, wb_seen;

    s   = int'((addr >> 5) % NS);
    tag = addr >> 8;
    la  = addr >> 5;
    p_hit = 1'b0;
    w     = 0;
    for (int i = 0; i < NW; i++) if (mv[s][i] && mt[s][i] == tag) begin p_hit = 1'b1; w = i; end
    p_wb      = 1'b0;
    p_wb_addr = '0;
    p_wb_data = '0;
    if (!p_hit) begin
      w = -1;
      for (int i = NW - 1; i >= 0; i--) if (!mv[s][i]) w = i;
      if (w < 0) w = m_victim(s);
      if (mv[s][w] && md[s][w]) begin
        p_wb      = 1'b1;
        p_wb_addr = (mt[s][w] << 8) | (s << 5);
        p_wb_data = gold_get(p_wb_addr >> 5);
      end
      mv[s][w] = 1'b1;
      mt[s][w] = tag;
      md[s][w] = 1'b0;
    end
    m_touch(s, w);
    exp_rd = gold_get(la);
    if (we) begin
      line = exp_rd;
      for (int b = 0; b < 32; b++) if (be[b]) line[b*8 +: 8] = wd[b*8 +: 8];
      gold[la] = line;
      md[s][w] = 1'b1;
    end

    o_wb = 0; o_fill = 0; o_wb_addr = '0; o_fill_addr = '0; o_rdata = '0; wb_seen = '0;
    got = 0; excl_bad = 0; idle_nz = 0; wb_unstable = 0; align_bad = 0; lat = 0;
    @(negedge clk);
    mem_address        = addr;
    mem_write          = we;
    mem_read           = !we || both;
    mem_byte_enable256 = be;
    mem_wdata256       = wd;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (pmem_read && pmem_write) excl_bad = 1;
      if ((pmem_read || pmem_write) && pmem_address[4:0] != 5'd0) align_bad = 1;
      if (pmem_write) begin
        if (!o_wb) begin
          o_wb      = 1;
          o_wb_addr = pmem_address;
          wb_seen   = pmem_wdata;
        end else if (pmem_address !== o_wb_addr || pmem_wdata !== wb_seen) wb_unstable = 1;
      end
      if (pmem_read && !o_fill) begin
        o_fill      = 1;
        o_fill_addr = pmem_address;
      end
      if (mem_resp) begin
        got     = 1;
        lat     = cyc + 1;
        o_rdata = mem_rdata256;
        break;
      end else if (mem_rdata256 !== '0) idle_nz = 1;
    end
    @(negedge clk);
    resp_long = mem_resp;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    o_hit = got && !o_wb && !o_fill;

    check("resp_arrives", got, 1);
    check("resp_one_cycle", resp_long, 0);
    check("writeback_seen", o_wb, p_wb);
    if (p_wb) begin
      check("writeback_addr", o_wb_addr, p_wb_addr);
      check("writeback_data", wb_seen, p_wb_data);
    end
    check("fill_seen", o_fill, !p_hit);
    if (!p_hit) check("fill_addr", o_fill_addr, {addr[31:5], 5'd0});
    if (p_hit) check("hit_latency", lat, 2);
    if (!we) check("read_data", o_rdata, exp_rd);
    check("pmem_rd_wr_exclusive", excl_bad, 0);
    check("pmem_addr_aligned", align_bad, 0);
    check("writeback_stable", wb_unstable, 0);
    check("rdata_zero_without_resp", idle_nz, 0);
  endtask

  typedef struct {
    logic [31:0]  addr;
    bit           we;
    logic [31:0]  be;
    logic [255:0] wdata;
    bit           e_hit;
    bit           e_wb;
    logic [31:0]  e_wb_addr;
    logic [31:0]  e_fill_addr;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit o_hit, o_wb, o_fill, bad;
    logic [31:0] o_wb_addr, o_fill_addr, addr, be;
    logic [255:0] o_rdata, aa, exp_line, wd;
    int s;

    aa = {32{8'hAA}};
    //          addr        we  be            wdata e_hit e_wb  e_wb_addr  e_fill_addr
    tbl[0]  = '{32'h040, 1'b0, 32'h0,         '0,   1'b0, 1'b0, 32'h0,     32'h040};
    tbl[1]  = '{32'h040, 1'b0, 32'h0,         '0,   1'b1, 1'b0, 32'h0,     32'h0};
    tbl[2]  = '{32'h044, 1'b1, 32'h0000_00F0, aa,   1'b1, 1'b0, 32'h0,     32'h0};
    tbl[3]  = '{32'h040, 1'b0, 32'h0,         '0,   1'b1, 1'b0, 32'h0,     32'h0};
    tbl[4]  = '{32'h140, 1'b0, 32'h0,         '0,   1'b0, 1'b0, 32'h0,     32'h140};
    tbl[5]  = '{32'h240, 1'b0, 32'h0,         '0,   1'b0, 1'b0, 32'h0,     32'h240};
    tbl[6]  = '{32'h340, 1'b0, 32'h0,         '0,   1'b0, 1'b0, 32'h0,     32'h340};
    tbl[7]  = '{32'h440, 1'b0, 32'h0,         '0,   1'b0, 1'b1, 32'h040,   32'h440};
    tbl[8]  = '{32'h140, 1'b0, 32'h0,         '0,   1'b1, 1'b0, 32'h0,     32'h0};
    tbl[9]  = '{32'h340, 1'b0, 32'h0,         '0,   1'b1, 1'b0, 32'h0,     32'h0};
    tbl[10] = '{32'h540, 1'b0, 32'h0,         '0,   1'b0, 1'b0, 32'h0,     32'h540};
    tbl[11] = '{32'h040, 1'b0, 32'h0,         '0,   1'b0, 1'b0, 32'h0,     32'h040};

    rst = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable256 = '0; mem_wdata256 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_mem_resp", mem_resp, 0);
    check("reset_pmem_read", pmem_read, 0);
    check("reset_pmem_write", pmem_write, 0);
    check("reset_pmem_address", pmem_address, 0);
    check("reset_mem_rdata", mem_rdata256, 0);
    rst = 1'b1;

    // Directed vectors: first fill, hits, byte-masked write, PLRU eviction.
    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].addr, tbl[i].we, 1'b0, tbl[i].be, tbl[i].wdata,
             o_hit, o_wb, o_wb_addr, o_fill, o_fill_addr, o_rdata);
      check($sformatf("vec%0d_hit", i), o_hit, tbl[i].e_hit);
      check($sformatf("vec%0d_wb", i), o_wb, tbl[i].e_wb);
      if (tbl[i].e_wb) check($sformatf("vec%0d_wb_addr", i), o_wb_addr, tbl[i].e_wb_addr);
      if (!tbl[i].e_hit) check($sformatf("vec%0d_fill_addr", i), o_fill_addr, tbl[i].e_fill_addr);
`ifdef CACHE_PERF_COUNTERS_EN
      if (i == 2) begin
        check("hit_count", hit_count, 32'd3);
        check("miss_count", miss_count, 32'd1);
      end
`endif
      if (i == 11) begin
        exp_line = init_line(2);
        exp_line[63:32] = 32'hAAAA_AAAA;
        check("written_bytes_roundtrip", o_rdata, exp_line);
      end
    end

    // Reset during the second FILL cycle abandons the fill.
    mem_auto = 1'b0;
    @(negedge clk);
    mem_address = 32'h080;
    mem_read    = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pmem_read) begin bad = 1'b1; break; end
    end
    check("abort_fill_entered", bad, 1);
    @(negedge clk);
    check("abort_fill_cycle2", pmem_read, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_pmem_read", pmem_read, 0);
    check("abort_pmem_address", pmem_address, 0);
    check("abort_mem_resp", mem_resp, 0);
    rst      = 1'b1;
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 force_resp = 1'b1;
    @(posedge clk); #1 force_resp = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_resp || pmem_read || pmem_write) bad = 1'b1;
    end
    check("late_pmem_resp_ignored", bad, 0);
    model_reset();
    gold = pmem;
    mem_auto = 1'b1;
    do_req(32'h080, 1'b0, 1'b0, '0, '0, o_hit, o_wb, o_wb_addr, o_fill, o_fill_addr, o_rdata);
    check("abort_line_not_valid", o_fill, 1);
    check("abort_refill_addr", o_fill_addr, 32'h080);

    // Random traffic over two sets and six tags forces evictions and writebacks.
    for (int n = 0; n < 300; n++) begin
      s    = ($urandom % 2 == 0) ? 1 : 6;
      addr = ($urandom_range(0, 5) << 8) | (s << 5) | ($urandom % 32);
      be   = $urandom;
      for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom;
      if ($urandom % 3 == 0)
        do_req(addr, 1'b1, ($urandom % 2 == 1), be, wd, o_hit, o_wb, o_wb_addr, o_fill, o_fill_addr, o_rdata);
      else
        do_req(addr, 1'b0, 1'b0, be, wd, o_hit, o_wb, o_wb_addr, o_fill, o_fill_addr, o_rdata);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
